// File: rtl/chan_rr_arbiter_if.sv
// ============================================================================
//  Module      : chan_rr_arbiter_if
//  Description : Requester-side and channel-side signal bundle for the
//                round-robin channel arbiter. The master modport is the
//                arbiter; the slave modport is the environment around it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chan_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int CNT_W   = 16
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic                  out_ready;
    logic [SRC_W-1:0]      out_src;
    logic                  busy;
    logic [CNT_W-1:0]      xfer_cnt;
    logic                  timeout_err;

    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src, busy, xfer_cnt, timeout_err
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src, busy, xfer_cnt, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/chan_rr_arbiter.sv
// ============================================================================
//  Module      : chan_rr_arbiter
//  Description : Round-robin arbiter sharing one valid/ready channel between
//                NUM_REQ requesters, with a completed-transfer counter and a
//                sticky stall watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    chan_rr_arbiter_if.master ch
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SRC_W-1:0] r_last_grant;
    logic [SRC_W-1:0] r_out_src;
    logic [DW-1:0]    r_out_data;
    logic [CNT_W-1:0] r_xfer_cnt;
    logic [7:0]       r_wait_cnt;
    logic             r_timeout_err;

    logic [SRC_W-1:0] w_cand;
    logic [SRC_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic [DW-1:0]    w_sel_data;
    logic             w_cap;
    logic             w_grant;
    logic             w_done;

    // The output register may be reloaded when empty or when its word leaves.
    assign w_cap   = (r_state == S_IDLE) || ch.out_ready;
    assign w_grant = w_cap && w_gnt_vld;
    assign w_done  = (r_state == S_WAIT) && ch.out_ready;

    // Rotating priority search starting just above the previous winner.
    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = SRC_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_gnt_vld && ch.req_valid[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Select the winning requester's data word.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == SRC_W'(i)) begin
                w_sel_data = ch.req_data[i*DW +: DW];
            end
        end
    end

    assign ch.req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    // Next state: reload on a grant, drain to IDLE when nothing is pending.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cap) begin
            w_state_nxt = w_gnt_vld ? S_WAIT : S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted word; last_grant resets so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_last_grant <= SRC_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_out_data   <= w_sel_data;
            r_out_src    <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
        end
    end

    // Count words accepted by the channel; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_done) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
    end

    // Stall watchdog: counts stalled WAIT cycles, flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_grant || w_done) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT) && (r_wait_cnt < c_TIMEOUT)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            // Set on the same edge at which the stall count reaches TIMEOUT.
            if ((r_state == S_WAIT) && !ch.out_ready &&
                (r_wait_cnt >= (c_TIMEOUT - 8'd1))) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign ch.out_valid   = (r_state == S_WAIT);
    assign ch.busy        = (r_state == S_WAIT);
    assign ch.out_data    = r_out_data;
    assign ch.out_src     = r_out_src;
    assign ch.xfer_cnt    = r_xfer_cnt;
    assign ch.timeout_err = r_timeout_err;

endmodule

`default_nettype wire
